// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared, externally supplied ALU: grant, capture operands, wait LATENCY, return the result.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed priority to requester 0; round-robin otherwise.
module alu_arbiter #(
  parameter int LATENCY = 1  // legal 1..8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req_opa,
  input  logic [63:0] req_opb,
  input  logic [5:0]  req_cmd,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [31:0] resp_result,
  output logic [2:0]  resp_flags,
  output logic [31:0] alu_opa,
  output logic [31:0] alu_opb,
  output logic [2:0]  alu_cmd,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  state_t     state;
  logic       owner;
  logic [2:0] cnt;
  logic       gnt;
  logic       accept;

  logic [1:0][31:0] opa_l, opb_l;
  logic [1:0][2:0]  cmd_l;

  assign opa_l = req_opa;
  assign opb_l = req_opb;
  assign cmd_l = req_cmd;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt = 1'b0;
    if (req_valid != 2'b11) gnt = req_valid[1];
  end
`else
  logic last;  // most recently granted requester

  always_comb begin
    gnt = 1'b0;
    if (req_valid == 2'b11) gnt = ~last;
    else                    gnt = req_valid[1];
  end
`endif

  assign req_ready  = (state == IDLE && |req_valid) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign accept     = |(req_valid & req_ready);
  assign resp_valid = (state == RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      cnt         <= 3'd0;
      resp_result <= '0;
      resp_flags  <= '0;
      alu_opa     <= '0;
      alu_opb     <= '0;
      alu_cmd     <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last        <= 1'b1;  // so requester 0 wins the first tie
`endif
    end else begin
      case (state)
        IDLE: if (accept) begin
          alu_opa <= opa_l[gnt];
          alu_opb <= opb_l[gnt];
          alu_cmd <= cmd_l[gnt];
          owner   <= gnt;
          cnt     <= CNT_INIT;
          state   <= EXEC;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last    <= gnt;
`endif
        end
        EXEC: begin
          if (cnt == 3'd0) begin
            resp_result <= alu_result;
            resp_flags  <= alu_flags;
            state       <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: if (resp_ready[owner]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: one instance at LATENCY=1, one at LATENCY=4, each with a behavioural ALU on its shared-ALU port.
module tb_alu_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  a_req_valid = '0, a_req_ready, a_resp_valid, a_resp_ready = '0;
  logic [63:0] a_req_opa = '0, a_req_opb = '0;
  logic [5:0]  a_req_cmd = '0;
  logic [31:0] a_resp_result, a_alu_opa, a_alu_opb, a_alu_result;
  logic [2:0]  a_resp_flags, a_alu_cmd, a_alu_flags;
  logic        a_busy;

  logic [1:0]  b_req_valid = '0, b_req_ready, b_resp_valid, b_resp_ready = '0;
  logic [63:0] b_req_opa = '0, b_req_opb = '0;
  logic [5:0]  b_req_cmd = '0;
  logic [31:0] b_resp_result, b_alu_opa, b_alu_opb, b_alu_result;
  logic [2:0]  b_resp_flags, b_alu_cmd, b_alu_flags;
  logic        b_busy;

  alu_arbiter #(.LATENCY(LAT_A)) u_a (
    .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_opa(a_req_opa), .req_opb(a_req_opb), .req_cmd(a_req_cmd),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_result(a_resp_result),
    .resp_flags(a_resp_flags), .alu_opa(a_alu_opa), .alu_opb(a_alu_opb), .alu_cmd(a_alu_cmd),
    .alu_result(a_alu_result), .alu_flags(a_alu_flags), .busy(a_busy));

  alu_arbiter #(.LATENCY(LAT_B)) u_b (
    .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_opa(b_req_opa), .req_opb(b_req_opb), .req_cmd(b_req_cmd),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_result(b_resp_result),
    .resp_flags(b_resp_flags), .alu_opa(b_alu_opa), .alu_opb(b_alu_opb), .alu_cmd(b_alu_cmd),
    .alu_result(b_alu_result), .alu_flags(b_alu_flags), .busy(b_busy));

  // Returns {carryout, zero, overflow, result}
  function automatic logic [34:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    logic [32:0] s;
    logic [31:0] r;
    logic co, ov;
    s = '0; r = '0; co = 1'b0; ov = 1'b0;
    case (c)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b}; r = s[31:0]; co = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1, 3'd3: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; co = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
        if (c == 3'd3) r = {31'd0, $signed(a) < $signed(b)};
      end
      3'd2: r = a ^ b;
      3'd4: r = a & b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      default: r = a | b;
    endcase
    return {co, (r == 32'd0), ov, r};
  endfunction

  always_comb {a_alu_flags, a_alu_result} = alu_ref(a_alu_opa, a_alu_opb, a_alu_cmd);
  always_comb {b_alu_flags, b_alu_result} = alu_ref(b_alu_opa, b_alu_opb, b_alu_cmd);

  typedef struct {
    logic        owner;
    logic [31:0] res;
    logic [2:0]  flg;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   acc_cyc = 0;

  task automatic do_reset;
    reset = 1'b1;
    a_req_valid = '0; a_resp_ready = '0;
    b_req_valid = '0; b_resp_ready = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sb.delete();
  endtask

  // Bounded wait (starting at a negedge) for an accept on instance a; g = granted requester.
  task automatic a_wait_accept(output logic g);
    g = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (|(a_req_valid & a_req_ready)) begin
        g = a_req_ready[1];
        acc_cyc = cyc;
        return;
      end
      @(negedge clk);
    end
    checks++; errors++;
    $display("FAIL accept_timeout: no accept within 20 cycles, req_ready=%b req_valid=%b", a_req_ready, a_req_valid);
  endtask

  // Wait for the response of the last accept on instance a, check it against the scoreboard, take it.
  task automatic a_serve;
    int n;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (a_resp_valid == 2'b00 && n < 20);
    checks++;
    if (n !== LAT_A + 1) begin
      errors++; $display("FAIL resp_latency: got %0d cycles, want %0d", n, LAT_A + 1);
    end
    if (sb.size() == 0) begin
      checks++; errors++; $display("FAIL scoreboard_empty: resp_valid=%b with nothing expected", a_resp_valid);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (a_resp_valid !== (e.owner ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL resp_owner: resp_valid=%b, want owner %0d", a_resp_valid, e.owner);
    end
    checks++;
    if (a_resp_result !== e.res || a_resp_flags !== e.flg) begin
      errors++; $display("FAIL resp_data: got %h/%b, want %h/%b", a_resp_result, a_resp_flags, e.res, e.flg);
    end
    a_resp_ready = e.owner ? 2'b10 : 2'b01;
    @(negedge clk);
    a_resp_ready = 2'b00;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_req_ready, a_resp_valid, a_busy} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl_a: ready=%b resp_valid=%b busy=%b, want all 0", a_req_ready, a_resp_valid, a_busy);
    end
    checks++;
    if ({a_resp_result, a_resp_flags} !== 35'd0) begin
      errors++; $display("FAIL reset_resp_a: got %h/%b, want 0/000", a_resp_result, a_resp_flags);
    end
    checks++;
    if ({a_alu_opa, a_alu_opb, a_alu_cmd} !== 67'd0) begin
      errors++; $display("FAIL reset_alu_a: opa=%h opb=%h cmd=%0d, want 0", a_alu_opa, a_alu_opb, a_alu_cmd);
    end
    checks++;
    if ({b_req_ready, b_resp_valid, b_busy, b_resp_result, b_resp_flags, b_alu_opa, b_alu_opb, b_alu_cmd} !== 107'd0) begin
      errors++; $display("FAIL reset_b: busy=%b resp_valid=%b result=%h alu_opa=%h, want all 0", b_busy, b_resp_valid, b_resp_result, b_alu_opa);
    end
    reset = 1'b0;
  endtask

  task automatic test_single;
    exp_t e;
    do_reset;
    a_req_opa[31:0] = 32'd5; a_req_opb[31:0] = 32'd3; a_req_cmd[2:0] = 3'd0;
    a_req_valid = 2'b01;
    #1;
    checks++;
    if (a_req_ready !== 2'b01) begin
      errors++; $display("FAIL single_grant: req_ready=%b, want 01", a_req_ready);
    end
    sb.push_back('{1'b0, 32'd8, 3'b000});
    @(negedge clk);
    a_req_valid = 2'b10;  // request change during EXEC must not be seen
    #1;
    checks++;
    if (a_req_ready !== 2'b00 || a_busy !== 1'b1 || a_resp_valid !== 2'b00) begin
      errors++; $display("FAIL single_exec: ready=%b busy=%b resp_valid=%b, want 00/1/00", a_req_ready, a_busy, a_resp_valid);
    end
    checks++;
    if (a_alu_opa !== 32'd5 || a_alu_opb !== 32'd3 || a_alu_cmd !== 3'd0) begin
      errors++; $display("FAIL single_alu_ops: %h %h %0d, want 5 3 0", a_alu_opa, a_alu_opb, a_alu_cmd);
    end
    @(negedge clk);
    a_req_valid = 2'b00;
    checks++;
    if (a_resp_valid !== 2'b01) begin
      errors++; $display("FAIL single_resp_valid: got %b two cycles after accept, want 01", a_resp_valid);
    end
    e = sb.pop_front();
    checks++;
    if (a_resp_result !== e.res || a_resp_flags !== e.flg) begin
      errors++; $display("FAIL single_data: got %h/%b, want %h/%b", a_resp_result, a_resp_flags, e.res, e.flg);
    end
    a_resp_ready = 2'b10;
    @(negedge clk);
    checks++;
    if (a_resp_valid !== 2'b01 || a_resp_result !== 32'd8) begin
      errors++; $display("FAIL nonowner_ready: resp_valid=%b result=%h, want 01/8", a_resp_valid, a_resp_result);
    end
    a_resp_ready = 2'b01;
    @(negedge clk);
    a_resp_ready = 2'b00;
    checks++;
    if (a_resp_valid !== 2'b00 || a_busy !== 1'b0 || a_alu_opa !== 32'd5) begin
      errors++; $display("FAIL single_done: resp_valid=%b busy=%b alu_opa=%h, want 00/0/5", a_resp_valid, a_busy, a_alu_opa);
    end
  endtask

  task automatic test_round_robin;
    logic g;
    logic [3:0] want;
    int prev;
`ifdef ALU_ARB_FIXED_PRIO_EN
    want = 4'b0000;
`else
    want = 4'b1010;  // grant sequence 0,1,0,1 read from bit 0 upward
`endif
    do_reset;
    a_req_opa = {32'd2, 32'd7}; a_req_opb = {32'd9, 32'd7}; a_req_cmd = {3'd3, 3'd1};
    a_req_valid = 2'b11;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      a_wait_accept(g);
      checks++;
      if (g !== want[k]) begin
        errors++; $display("FAIL rr_grant%0d: granted %0d, want %0d", k, g, want[k]);
      end
      if (k > 0) begin
        checks++;
        if (acc_cyc - prev !== LAT_A + 2) begin
          errors++; $display("FAIL rr_spacing%0d: %0d cycles, want %0d", k, acc_cyc - prev, LAT_A + 2);
        end
      end
      prev = acc_cyc;
      if (g) sb.push_back('{1'b1, 32'd1, 3'b000});
      else   sb.push_back('{1'b0, 32'd0, 3'b110});
      a_serve;
    end
    a_req_valid = 2'b00;
  endtask

  task automatic test_reset_abort;
    logic g;
    logic seen;
    do_reset;
    a_req_opa[31:0] = 32'h0000_F0F0; a_req_opb[31:0] = 32'h0000_FF00; a_req_cmd[2:0] = 3'd4;
    a_req_valid = 2'b01;
    a_wait_accept(g);
    @(negedge clk);
    a_req_valid = 2'b00;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (a_busy !== 1'b0 || a_resp_result !== 32'd0) begin
      errors++; $display("FAIL abort_busy: busy=%b result=%h, want 0/0", a_busy, a_resp_result);
    end
    seen = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (a_resp_valid !== 2'b00) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_no_resp: resp_valid rose after aborted request");
    end
    a_req_opa[63:32] = 32'h0000_000F; a_req_opb[63:32] = 32'h0000_00F0; a_req_cmd[5:3] = 3'd7;
    a_req_valid = 2'b10;
    a_wait_accept(g);
    checks++;
    if (g !== 1'b1) begin
      errors++; $display("FAIL abort_next_grant: granted %0d, want 1", g);
    end
    sb.push_back('{1'b1, 32'h0000_00FF, 3'b000});
    a_serve;
    a_req_valid = 2'b00;
  endtask

  task automatic test_overflow_hold;
    int n;
    exp_t e;
    do_reset;
    b_req_opa[31:0] = 32'h7FFF_FFFF; b_req_opb[31:0] = 32'd1; b_req_cmd[2:0] = 3'd0;
    b_req_valid = 2'b01;
    #1;
    checks++;
    if (b_req_ready !== 2'b01) begin
      errors++; $display("FAIL ovf_grant: req_ready=%b, want 01", b_req_ready);
    end
    sb.push_back('{1'b0, 32'h8000_0000, 3'b001});
    n = 0;
    do begin
      @(negedge clk);
      b_req_valid = 2'b00;
      n++;
    end while (b_resp_valid == 2'b00 && n < 20);
    checks++;
    if (n !== LAT_B + 1) begin
      errors++; $display("FAIL ovf_latency: got %0d cycles, want %0d", n, LAT_B + 1);
    end
    e = sb.pop_front();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (b_resp_valid !== 2'b01 || b_resp_result !== e.res || b_resp_flags !== e.flg) begin
        errors++; $display("FAIL ovf_hold%0d: %b %h/%b, want 01 %h/%b", k, b_resp_valid, b_resp_result, b_resp_flags, e.res, e.flg);
      end
      b_resp_ready = (k == 1) ? 2'b10 : 2'b00;
      @(negedge clk);
    end
    b_resp_ready = 2'b01;
    @(negedge clk);
    b_resp_ready = 2'b00;
    checks++;
    if (b_resp_valid !== 2'b00 || b_busy !== 1'b0) begin
      errors++; $display("FAIL ovf_release: resp_valid=%b busy=%b, want 00/0", b_resp_valid, b_busy);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_single;
    test_round_robin;
    test_reset_abort;
    test_overflow_hold;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
